meas_sched: RTL and testbench
=============================

Name: meas_sched

Overview:
- Round-robin measurement scheduler in the prim_clk domain; sequences the analog conversion controller over up to NCH front-end channels.
- Per channel: drives the AFE select, issues a one-cycle trigger, waits for data/end-of-phase with timeout, then presents the result on a valid/ready stream (e.g. to the UART framer).
- Rounds are separated by a programmable idle period.

Parameters:
NCH, 4, number of scheduled channels (2..16)
DATA_W, 12, measurement data width
PERIOD_W, 16, width of inter-round idle counter
TIMEOUT, 1023, max cycles in CONVERT before abort

Ports:
prim_clk  in  1  clock
prim_rst  in  1  synchronous reset, active-high
enable  in  1  run request
ch_mask  in  NCH  channel enable mask, latched at round start
period  in  PERIOD_W  idle cycles between rounds, latched at round start
trig  out  1  one-cycle conversion start pulse
afe_sel  out  4  selected channel index
meas_data  in  DATA_W  processed result
meas_data_p  in  1  meas_data valid pulse
meas_eop  in  1  end-of-phase pulse
res_valid  out  1  result available
res_ready  in  1  sink accepts result
res_data  out  DATA_W  result value
res_ch  out  4  channel of result
busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky conversion timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: all outputs 0, state IDLE, channel pointer 0, latched mask 0.
- States: IDLE, SELECT, TRIG, CONVERT, PUSH, NEXT, WAIT.
- IDLE: enable=1 and ch_mask!=0 -> latch ch_mask and period, pointer = lowest set bit, go SELECT. ch_mask=0 -> stay IDLE.
- SELECT (1 cycle): afe_sel <= pointer; go TRIG.
- TRIG (1 cycle): trig=1; clear timeout counter; go CONVERT.
- Latency: trig high exactly 2 cycles after the IDLE cycle where enable is sampled high.
- CONVERT:
  - meas_data_p captures meas_data into the result register.
  - meas_eop -> PUSH if data was captured this conversion, else NEXT with no result.
  - meas_data_p and meas_eop in the same cycle: capture, then PUSH.
  - Counter reaching TIMEOUT with no meas_eop: set timeout_err, go NEXT.
  - meas_eop in the timeout cycle: meas_eop wins, no error.
- PUSH:
  - res_valid=1 with res_data and res_ch stable until res_valid & res_ready; then go NEXT.
  - res_valid is never deasserted without a handshake.
- NEXT:
  - Next set bit of the latched mask above the pointer exists -> pointer moves to it, go SELECT.
  - Otherwise round complete: period!=0 -> WAIT with counter=period; period=0 -> round restart.
- WAIT: decrement each cycle; at 1 -> round restart.
- Round restart:
  - enable=1 and ch_mask!=0: relatch ch_mask and period, pointer = lowest set bit, go SELECT.
  - Otherwise go IDLE.
- enable deasserted mid-round: the current channel completes (conversion and push), then IDLE from NEXT. No new trig is issued after enable is seen low at NEXT.
- ch_mask or period changes mid-round: ignored until the next round start.
- err_clr: clears timeout_err. A new timeout in the same cycle wins, so the flag stays set.
- prim_rst mid-operation: immediate return to IDLE. Any pending result is dropped and res_valid goes to 0 on the next cycle.

Optional Feature:
- Macro MEAS_SCHED_AVG4_EN.
- Defined:
  - Each channel is triggered 4 times back to back (TRIG→CONVERT repeated) before PUSH.
  - Captured samples accumulate in a DATA_W+2 bit register.
  - res_data = accumulator[DATA_W+1:2] (truncating average).
  - A timeout on any of the 4 conversions aborts the channel: no push, timeout_err set.
- Undefined: single conversion per channel as above; no accumulator logic.

Test Plan:
- ch_mask=4'b1010, period=5, enable held, res_ready=1, meas_data_p+meas_eop returned 10 cycles after each trig with data 0x123 then 0x456 -> results (ch1,0x123),(ch3,0x456); next round's trig occurs after 5 WAIT cycles; afe_sel sequence 1,3,1,3.
- No meas_eop after trig, TIMEOUT=1023 -> timeout_err=1 exactly 1023 cycles after entering CONVERT, no res_valid, scheduler moves on. err_clr pulse -> timeout_err=0.
- res_ready=0 for 20 cycles during PUSH -> res_valid stays high, res_data/res_ch stable, no new trig; res_ready=1 -> one handshake, then NEXT.
- enable dropped while ch0 in CONVERT with mask 4'b1111 -> ch0 result pushed, no trig for ch1, busy=0 two cycles after handshake.
- meas_eop and timeout counter expiry in the same cycle, and meas_data_p+meas_eop coincident -> no timeout_err, result pushed.
- MEAS_SCHED_AVG4_EN defined, ch_mask=4'b0001, samples 0x100,0x101,0x102,0x103 -> exactly 4 trig pulses, single result res_data=0x101.

Source files
------------

// File: rtl/meas_sched.sv
// meas_sched: round-robin measurement scheduler for the analog conversion
// controller. For each enabled channel, in ascending index order, it
// selects the AFE input, fires a one-cycle trigger, and collects the
// result (or gives up on a timeout). Each result is then offered on a
// valid/ready stream. Rounds are separated by a programmable idle gap.
//
// Optional build macro MEAS_SCHED_AVG4_EN: every channel is converted four
// times back to back. The pushed result is the truncating mean of the four
// samples. When the macro is undefined, each channel gets one conversion.

`default_nettype none

module meas_sched #(
  parameter int NCH      = 4,
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                prim_clk,
  input  logic                prim_rst,
  input  logic                enable,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [PERIOD_W-1:0] period,
  output logic                trig,
  output logic [3:0]          afe_sel,
  input  logic [DATA_W-1:0]   meas_data,
  input  logic                meas_data_p,
  input  logic                meas_eop,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [3:0]          res_ch,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr
);

  // Timeout counter counts CONVERT cycles; it expires on the TIMEOUT-th one.
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_TRIG    = 3'd2,
    S_CONVERT = 3'd3,
    S_PUSH    = 3'd4,
    S_NEXT    = 3'd5,
    S_WAIT    = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [NCH-1:0]      mask_q, mask_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [3:0]          afe_sel_q, afe_sel_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [PERIOD_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                got_data_q, got_data_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [3:0]          res_ch_q, res_ch_d;
  logic                timeout_err_q, timeout_err_d;

`ifdef MEAS_SCHED_AVG4_EN
  logic [DATA_W+1:0]   acc_q, acc_d;
  logic [1:0]          rep_q, rep_d;
  logic [DATA_W+1:0]   acc_sum;
`endif

  logic [NCH-1:0] above_vec;
  logic           has_next;
  logic           restart_ok;
  logic           to_hit;
  logic           wait_done;
  logic           data_seen;
  logic           last_rep;
  logic           advance;
  logic           round_start;
  logic           timeout_set;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [3:0] lowest_idx(input logic [NCH-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Latched-mask channels strictly above the current pointer.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_above
      assign above_vec[gi] = mask_q[gi] & (4'(gi) > ptr_q);
    end
  endgenerate

  assign has_next    = |above_vec;
  assign restart_ok  = enable & (|ch_mask);
  assign to_hit      = (to_cnt_q == TO_LAST);
  assign wait_done   = (wait_cnt_q == PERIOD_W'(1));
  assign data_seen   = got_data_q | meas_data_p;
  assign timeout_set = (state_q == S_CONVERT) & ~meas_eop & to_hit;
  // Moving to the next channel of the same round, as opposed to starting a round.
  assign advance     = (state_q == S_NEXT) & enable & has_next;
  assign round_start = (state_d == S_SELECT) & ~advance;

`ifdef MEAS_SCHED_AVG4_EN
  assign acc_sum  = acc_q + (meas_data_p ? {2'b00, meas_data} : '0);
  assign last_rep = (rep_q == 2'd3);
`else
  assign last_rep = 1'b1;
`endif

  // State register.
  always_ff @(posedge prim_clk) begin
    if (prim_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode: per-channel sequencing and round control.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (restart_ok) state_d = S_SELECT;
      S_SELECT:  state_d = S_TRIG;
      S_TRIG:    state_d = S_CONVERT;
      S_CONVERT: begin
        // End-of-phase has priority over an expiring timeout.
        if (meas_eop) begin
          if (!data_seen)    state_d = S_NEXT;
          else if (last_rep) state_d = S_PUSH;
          else               state_d = S_TRIG;
        end else if (to_hit) begin
          state_d = S_NEXT;
        end
      end
      S_PUSH:    if (res_ready) state_d = S_NEXT;
      S_NEXT: begin
        if (!enable)              state_d = S_IDLE;
        else if (has_next)        state_d = S_SELECT;
        else if (period_q != '0)  state_d = S_WAIT;
        else if (restart_ok)      state_d = S_SELECT;
        else                      state_d = S_IDLE;
      end
      S_WAIT: begin
        if (wait_done) state_d = restart_ok ? S_SELECT : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    trig      = (state_q == S_TRIG);
    res_valid = (state_q == S_PUSH);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next values: round latches, pointer, counters, result and error flag.
  always_comb begin
    mask_d        = mask_q;
    period_d      = period_q;
    ptr_d         = ptr_q;
    afe_sel_d     = afe_sel_q;
    to_cnt_d      = to_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    got_data_d    = got_data_q;
    res_data_d    = res_data_q;
    res_ch_d      = res_ch_q;
    timeout_err_d = timeout_err_q;
`ifdef MEAS_SCHED_AVG4_EN
    acc_d         = acc_q;
    rep_d         = rep_q;
`endif

    // Mask and period are only sampled when a round begins.
    if (round_start) begin
      mask_d   = ch_mask;
      period_d = period;
      ptr_d    = lowest_idx(ch_mask);
    end else if (advance) begin
      ptr_d    = lowest_idx(above_vec);
    end

    unique case (state_q)
      S_SELECT: begin
        afe_sel_d = ptr_q;
`ifdef MEAS_SCHED_AVG4_EN
        acc_d     = '0;
        rep_d     = '0;
`endif
      end
      S_TRIG: begin
        to_cnt_d   = '0;
        got_data_d = 1'b0;
      end
      S_CONVERT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (meas_data_p) begin
          got_data_d = 1'b1;
`ifdef MEAS_SCHED_AVG4_EN
          acc_d      = acc_sum;
`else
          res_data_d = meas_data;
`endif
        end
        if (meas_eop && data_seen) begin
          if (last_rep) begin
            res_ch_d   = afe_sel_q;
`ifdef MEAS_SCHED_AVG4_EN
            res_data_d = acc_sum[DATA_W+1:2];
`endif
          end
`ifdef MEAS_SCHED_AVG4_EN
          else begin
            rep_d = rep_q + 2'd1;
          end
`endif
        end
      end
      S_NEXT: begin
        if (state_d == S_WAIT) wait_cnt_d = period_q;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - PERIOD_W'(1);
      end
      default: ;
    endcase

    // A fresh timeout beats a simultaneous clear.
    if (timeout_set)  timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge prim_clk) begin
    if (prim_rst) begin
      mask_q        <= '0;
      period_q      <= '0;
      ptr_q         <= '0;
      afe_sel_q     <= '0;
      to_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      got_data_q    <= 1'b0;
      res_data_q    <= '0;
      res_ch_q      <= '0;
      timeout_err_q <= 1'b0;
`ifdef MEAS_SCHED_AVG4_EN
      acc_q         <= '0;
      rep_q         <= '0;
`endif
    end else begin
      mask_q        <= mask_d;
      period_q      <= period_d;
      ptr_q         <= ptr_d;
      afe_sel_q     <= afe_sel_d;
      to_cnt_q      <= to_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      got_data_q    <= got_data_d;
      res_data_q    <= res_data_d;
      res_ch_q      <= res_ch_d;
      timeout_err_q <= timeout_err_d;
`ifdef MEAS_SCHED_AVG4_EN
      acc_q         <= acc_d;
      rep_q         <= rep_d;
`endif
    end
  end

  assign afe_sel     = afe_sel_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_meas_sched.sv
// Testbench for meas_sched: directed scenarios plus randomized rounds.
// The bench plays the AFE side: it answers each trigger with samples it
// chooses itself. Expected results are the samples (or their truncating
// mean when four conversions per channel are built in). Expected trigger
// gaps come from the round rules: 2 cycles from a start decision to
// trigger, plus the idle period at the end of a round.

module tb_meas_sched;

  localparam int NCH      = 4;
  localparam int DATA_W   = 12;
  localparam int PERIOD_W = 16;
  localparam int TIMEOUT  = 1023;
`ifdef MEAS_SCHED_AVG4_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic                prim_clk = 1'b0;
  logic                prim_rst;
  logic                enable;
  logic [NCH-1:0]      ch_mask;
  logic [PERIOD_W-1:0] period;
  logic                trig;
  logic [3:0]          afe_sel;
  logic [DATA_W-1:0]   meas_data;
  logic                meas_data_p;
  logic                meas_eop;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_data;
  logic [3:0]          res_ch;
  logic                busy;
  logic                timeout_err;
  logic                err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NCH-1:0]      orig_mask;
  logic [PERIOD_W-1:0] orig_per;

  meas_sched #(
    .NCH(NCH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .prim_clk(prim_clk), .prim_rst(prim_rst), .enable(enable),
    .ch_mask(ch_mask), .period(period), .trig(trig), .afe_sel(afe_sel),
    .meas_data(meas_data), .meas_data_p(meas_data_p), .meas_eop(meas_eop),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ch(res_ch), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 prim_clk = ~prim_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge prim_clk);
  endtask

  task automatic wait_trig(input int maxc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!trig && n < maxc);
    chk("trig_seen", 32'(trig), 32'd1);
  endtask

  // Serve one channel: trigger(s), sample return, then the push handshake.
  // drop: 0 keep enable, 1 drop at trigger, 2 drop at handshake.
  task automatic do_channel(input int gap, input logic [3:0] ch, input logic [47:0] smp,
                            input int dly, input int split, input int stall,
                            input int drop, input bit junk, input bit restore);
    int n;
    int sum;
    logic [DATA_W-1:0] expd;
    if (gap > 0) begin
      wait_trig(gap + 20, n);
      chk("trig_gap", 32'(n), 32'(gap));
    end else begin
      chk("trig_now", 32'(trig), 32'd1);
    end
    chk("afe_sel", 32'(afe_sel), 32'(ch));
    if (junk) begin
      ch_mask = 4'($urandom_range(0, 15));
      period  = 16'($urandom_range(0, 30));
    end
    if (drop == 1) enable = 1'b0;
    sum = 0;
    for (int c = 0; c < NCONV; c++) begin
      if (c > 0) chk("avg_retrig", 32'(trig), 32'd1);
      sum += int'(smp[12*c +: 12]);
      repeat (dly) tick();
      chk("no_valid_in_conv", 32'(res_valid), 32'd0);
      meas_data   = smp[12*c +: 12];
      meas_data_p = 1'b1;
      if (split == 0) meas_eop = 1'b1;
      tick();
      meas_data_p = 1'b0;
      meas_eop    = 1'b0;
      meas_data   = 12'($urandom);
      if (split > 0) begin
        repeat (split - 1) tick();
        meas_eop = 1'b1;
        tick();
        meas_eop = 1'b0;
      end
    end
    expd = 12'(sum / NCONV);
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(expd));
    chk("res_ch", 32'(res_ch), 32'(ch));
    $display("[TB] push ch=%0d data=0x%0h (expect ch=%0d data=0x%0h)", res_ch, res_data, ch, expd);
    if (restore) begin
      ch_mask = orig_mask;
      period  = orig_per;
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_data", 32'(res_data), 32'(expd));
      chk("stall_ch", 32'(res_ch), 32'(ch));
      chk("stall_no_trig", 32'(trig), 32'd0);
    end
    if (drop == 2) enable = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Called at the NEXT cycle after the final handshake with enable low.
  task automatic end_check();
    int nt;
    chk("busy_next", 32'(busy), 32'd1);
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    nt = 0;
    repeat (8) begin
      tick();
      if (trig) nt++;
    end
    chk("no_trig_after_stop", 32'(nt), 32'd0);
  endtask

  initial begin
    int n;
    prim_rst = 1'b1; enable = 1'b0; ch_mask = '0; period = '0;
    meas_data = '0; meas_data_p = 1'b0; meas_eop = 1'b0;
    res_ready = 1'b0; err_clr = 1'b0;
    orig_mask = '0; orig_per = '0;
    repeat (3) tick();
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_afe_sel", 32'(afe_sel), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_ch", 32'(res_ch), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    prim_rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Mask 1010, period 5: ch1/ch3 twice, stall 20 on the second ch1 push.
    ch_mask = 4'b1010; period = 16'd5; enable = 1'b1;
    do_channel(2, 4'd1, {4{12'h123}}, 10, 0, 0, 0, 0, 0);
    do_channel(2, 4'd3, {4{12'h456}}, 10, 0, 0, 0, 0, 0);
    do_channel(7, 4'd1, {4{12'h123}}, 10, 0, 20, 0, 0, 0);
    do_channel(2, 4'd3, {4{12'h456}}, 10, 0, 0, 2, 0, 0);
    end_check();

    // End-of-phase without data: no push, move on to the next channel.
    ch_mask = 4'b0110; period = 16'd0; enable = 1'b1;
    wait_trig(30, n);
    chk("eoponly_gap", 32'(n), 32'd2);
    chk("eoponly_sel", 32'(afe_sel), 32'd1);
    repeat (5) tick();
    meas_eop = 1'b1;
    tick();
    meas_eop = 1'b0;
    chk("eoponly_no_valid", 32'(res_valid), 32'd0);
    wait_trig(30, n);
    chk("eoponly_next_gap", 32'(n), 32'd2);
    do_channel(0, 4'd2, {4{12'hABC}}, 4, 2, 1, 2, 0, 0);
    end_check();

    // Enable dropped during ch0 conversion with all channels enabled.
    ch_mask = 4'hF; period = 16'd0; enable = 1'b1;
    do_channel(2, 4'd0, {4{12'h5A5}}, 6, 1, 2, 1, 0, 0);
    end_check();

    // Timeout: flag exactly TIMEOUT cycles after entering CONVERT.
    ch_mask = 4'b0001; period = 16'd0; enable = 1'b1;
    wait_trig(30, n);
    chk("to_gap", 32'(n), 32'd2);
    repeat (TIMEOUT) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_no_valid", 32'(res_valid), 32'd0);
    chk("to_busy_next", 32'(busy), 32'd1);
    wait_trig(30, n);
    chk("to_moves_on", 32'(n), 32'd2);
    // Second timeout coincides with err_clr: the flag stays set.
    repeat (TIMEOUT) tick();
    err_clr = 1'b1;
    enable  = 1'b0;
    tick();
    chk("to_beats_clr", 32'(timeout_err), 32'd1);
    tick();
    chk("clr_works", 32'(timeout_err), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    err_clr = 1'b0;

    // Data and end-of-phase arriving exactly in the timeout cycle.
    ch_mask = 4'b0001; enable = 1'b1;
    do_channel(2, 4'd0, {4{12'h7E1}}, TIMEOUT, 0, 0, 2, 0, 0);
    chk("eop_beats_to", 32'(timeout_err), 32'd0);
    end_check();

    // Sample set 0x100..0x103 on ch0 (mean 0x101 when averaging).
    ch_mask = 4'b0001; enable = 1'b1;
    do_channel(2, 4'd0, {12'h103, 12'h102, 12'h101, 12'h100}, 5, 0, 0, 2, 0, 0);
    end_check();

    // Reset while a result is pending drops it.
    ch_mask = 4'b0001; enable = 1'b1;
    wait_trig(30, n);
    for (int c = 0; c < NCONV; c++) begin
      repeat (4) tick();
      meas_data = 12'h3C3; meas_data_p = 1'b1; meas_eop = 1'b1;
      tick();
      meas_data_p = 1'b0; meas_eop = 1'b0;
    end
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    prim_rst = 1'b1; enable = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_sel", 32'(afe_sel), 32'd0);
    prim_rst = 1'b0;
    tick();

    // Randomized rounds with mid-round mask/period disturbance.
    for (int sc = 0; sc < 6; sc++) begin
      logic [3:0] m;
      int p;
      int top;
      int gap;
      bit first;
      m   = 4'($urandom_range(1, 15));
      p   = $urandom_range(0, 6);
      top = 0;
      for (int b = 0; b < 4; b++) if (m[b]) top = b;
      orig_mask = m; orig_per = 16'(p);
      ch_mask = m; period = 16'(p); enable = 1'b1;
      gap = 2;
      for (int r = 0; r < 2; r++) begin
        first = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (m[b]) begin
            do_channel(gap, 4'(b),
                       {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)},
                       $urandom_range(1, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                       (r == 1 && b == top) ? 2 : 0, first, (b == top));
            first = 1'b0;
            gap = (b == top) ? 2 + p : 2;
          end
        end
      end
      end_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
